// File: rtl/fcu_pkg.sv
// Shared constants, field layout and opcode-class decode for the forwarding control unit.
package fcu_pkg;

    localparam int unsigned AW  = 5;
    localparam int unsigned IW  = 32;
    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 6;
    localparam int unsigned SW  = 2;

    // Instruction field bit positions (RB aliases the top of imm)
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RW_MSB  = 25;
    localparam int unsigned RW_LSB  = 21;
    localparam int unsigned RA_MSB  = 20;
    localparam int unsigned RA_LSB  = 16;
    localparam int unsigned RB_MSB  = 15;
    localparam int unsigned RB_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    // Opcode classes
    localparam logic [OPW-1:0] OP_NOP      = 6'b000000;
    localparam logic [2:0]     OP_RALU_PFX = 3'b000;
    localparam logic [2:0]     OP_IALU_PFX = 3'b001;
    localparam logic [OPW-1:0] OP_LOAD     = 6'b010000;
    localparam logic [OPW-1:0] OP_STORE    = 6'b010001;
    localparam logic [2:0]     OP_BR_PFX   = 3'b011;

    // Operand source selects
    typedef enum logic [SW-1:0] {
        SEL_RF = 2'b00,
        SEL_EX = 2'b01,
        SEL_DM = 2'b10,
        SEL_WB = 2'b11
    } sel_e;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [AW-1:0]  rw;
        logic [AW-1:0]  ra;
        logic [AW-1:0]  rb;
        logic [DW-1:0]  imm;
    } fields_t;

    // Split a raw instruction into its (overlapping) fields
    function automatic fields_t fcu_fields(input logic [IW-1:0] ins);
        fields_t f;
        f.op  = ins[OP_MSB:OP_LSB];
        f.rw  = ins[RW_MSB:RW_LSB];
        f.ra  = ins[RA_MSB:RA_LSB];
        f.rb  = ins[RB_MSB:RB_LSB];
        f.imm = ins[IMM_MSB:IMM_LSB];
        return f;
    endfunction

    // R-type ALU, I-type ALU and LOAD write RW; everything else does not
    function automatic logic fcu_writes(input logic [OPW-1:0] op);
        return ((op[5:3] == OP_RALU_PFX) && (op != OP_NOP)) ||
               (op[5:3] == OP_IALU_PFX) ||
               (op == OP_LOAD);
    endfunction

    // B operand comes from imm for I-type ALU, LOAD and STORE
    function automatic logic fcu_imm_sel(input logic [OPW-1:0] op);
        return (op[5:3] == OP_IALU_PFX) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/fcu_src_match.sv
// Picks the youngest in-flight producer of one source register.
module fcu_src_match
    import fcu_pkg::*;
(
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_d0,
    input  logic [AW-1:0] i_d1,
    input  logic [AW-1:0] i_d2,
    output logic [SW-1:0] o_sel_c
);

    // Priority EX > DM > WB; R0 never forwards
    always_comb begin
        o_sel_c = SEL_RF;
        if (i_src != '0) begin
            if (i_src == i_d0) begin
                o_sel_c = SEL_EX;
            end else if (i_src == i_d1) begin
                o_sel_c = SEL_DM;
            end else if (i_src == i_d2) begin
                o_sel_c = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/forwarding_control_unit.sv
// Decode/hazard stage: latches the fetched instruction and drives forwarding selects.
module forwarding_control_unit
    import fcu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IW-1:0]  ins,
    input  logic           stall,
    input  logic           flush,
    output logic [AW-1:0]  RA,
    output logic [AW-1:0]  RB,
    output logic [DW-1:0]  imm,
    output logic           imm_sel,
    output logic [SW-1:0]  mux_sel_A,
    output logic [SW-1:0]  mux_sel_B,
    output logic [AW-1:0]  RW_dm,
    output logic [OPW-1:0] op_out
);

    logic [IW-1:0]  w_ins;
    fields_t        w_f;
    logic [AW-1:0]  w_dest;
    logic           w_imm_sel;
    logic [SW-1:0]  w_sel_a;
    logic [SW-1:0]  w_sel_b_raw;
    logic [SW-1:0]  w_sel_b;

    logic [AW-1:0]  r_d0;
    logic [AW-1:0]  r_d1;
    logic [AW-1:0]  r_d2;
    logic [AW-1:0]  r_ra;
    logic [AW-1:0]  r_rb;
    logic [DW-1:0]  r_imm;
    logic           r_imm_sel;
    logic [SW-1:0]  r_sel_a;
    logic [SW-1:0]  r_sel_b;
    logic [AW-1:0]  r_rw_dm;
    logic [OPW-1:0] r_op;

    // Flushed slot becomes an all-zero NOP (no sources, no write)
    always_comb begin
        w_ins     = flush ? '0 : ins;
        w_f       = fcu_fields(w_ins);
        w_dest    = fcu_writes(w_f.op) ? w_f.rw : '0;
        w_imm_sel = fcu_imm_sel(w_f.op);
        // STORE keeps its B select since RB carries the store data
        w_sel_b   = (w_imm_sel && (w_f.op != OP_STORE)) ? SEL_RF : w_sel_b_raw;
    end

    fcu_src_match u_match_a (
        .i_src   (w_f.ra),
        .i_d0    (r_d0),
        .i_d1    (r_d1),
        .i_d2    (r_d2),
        .o_sel_c (w_sel_a)
    );

    fcu_src_match u_match_b (
        .i_src   (w_f.rb),
        .i_d0    (r_d0),
        .i_d1    (r_d1),
        .i_d2    (r_d2),
        .o_sel_c (w_sel_b_raw)
    );

    // Decode registers and destination pipe; stall freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_ra      <= '0;
            r_rb      <= '0;
            r_imm     <= '0;
            r_imm_sel <= 1'b0;
            r_sel_a   <= SEL_RF;
            r_sel_b   <= SEL_RF;
            r_rw_dm   <= '0;
            r_op      <= '0;
        end else if (!stall) begin
            r_d2      <= r_d1;
            r_d1      <= r_d0;
            r_d0      <= w_dest;
            r_rw_dm   <= r_d1;
            r_ra      <= w_f.ra;
            r_rb      <= w_f.rb;
            r_imm     <= w_f.imm;
            r_imm_sel <= w_imm_sel;
            r_sel_a   <= w_sel_a;
            r_sel_b   <= w_sel_b;
            r_op      <= w_f.op;
        end
    end

    assign RA        = r_ra;
    assign RB        = r_rb;
    assign imm       = r_imm;
    assign imm_sel   = r_imm_sel;
    assign mux_sel_A = r_sel_a;
    assign mux_sel_B = r_sel_b;
    assign RW_dm     = r_rw_dm;
    assign op_out    = r_op;

endmodule
